// File: rtl/pe_mac_controller.sv
// Job sequencer for a single registered-multiplier PE: streams len ifm/wgt pairs
// into the PE and folds the returned products into a saturating signed accumulator.
module pe_mac_controller #(
    parameter int INPUT_IFM_WIDTH = 8,
    parameter int INPUT_WGT_WIDTH = 8,
    parameter int OUTPUT_WIDTH    = 16,
    parameter int ACC_WIDTH       = 24,
    parameter int MAX_LEN         = 256,
    parameter int LEN_WIDTH       = $clog2(MAX_LEN + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [LEN_WIDTH-1:0]        len,
    output logic                        busy,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [INPUT_IFM_WIDTH-1:0]  in_ifm,
    input  logic [INPUT_WGT_WIDTH-1:0]  in_wgt,
    output logic [INPUT_IFM_WIDTH-1:0]  pe_ifm,
    output logic [INPUT_WGT_WIDTH-1:0]  pe_wgt,
    input  logic [OUTPUT_WIDTH-1:0]     pe_product,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_WIDTH-1:0]        out_acc,
    output logic                        out_sat
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    logic [LEN_WIDTH-1:0]   r_remaining;
    logic                   r_issue_d;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic                   r_sat;

    logic                   w_fire;
    logic [LEN_WIDTH-1:0]   w_len_clamped;
    logic [ACC_WIDTH:0]     w_prod_ext;
    logic [ACC_WIDTH:0]     w_sum;
    logic                   w_ovf_pos;
    logic                   w_ovf_neg;
    logic [ACC_WIDTH-1:0]   w_acc_sat;

    localparam logic [LEN_WIDTH-1:0] LP_MAX_LEN = LEN_WIDTH'(MAX_LEN);
    localparam logic [ACC_WIDTH-1:0] LP_ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] LP_ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    assign in_ready  = (r_state == S_RUN);
    assign busy      = (r_state != S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign out_acc   = r_acc;
    assign out_sat   = r_sat;

    assign w_fire = in_valid && in_ready;

    // Gate operands to zero outside an accepted pair so the PE never sees stale or X data.
    assign pe_ifm = w_fire ? in_ifm : '0;
    assign pe_wgt = w_fire ? in_wgt : '0;

    assign w_len_clamped = (len > LP_MAX_LEN) ? LP_MAX_LEN : len;

    // One guard bit above the accumulator: overflow shows as disagreement of the top two bits.
    assign w_prod_ext = {{(ACC_WIDTH + 1 - OUTPUT_WIDTH){pe_product[OUTPUT_WIDTH-1]}}, pe_product};
    assign w_sum      = {r_acc[ACC_WIDTH-1], r_acc} + w_prod_ext;
    assign w_ovf_pos  = ~w_sum[ACC_WIDTH] &  w_sum[ACC_WIDTH-1];
    assign w_ovf_neg  =  w_sum[ACC_WIDTH] & ~w_sum[ACC_WIDTH-1];
    assign w_acc_sat  = w_ovf_pos ? LP_ACC_MAX :
                        w_ovf_neg ? LP_ACC_MIN : w_sum[ACC_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_remaining <= '0;
            r_issue_d   <= 1'b0;
            r_acc       <= '0;
            r_sat       <= 1'b0;
        end else begin
            r_issue_d <= w_fire;

            if (r_issue_d) begin
                r_acc <= w_acc_sat;
                if (w_ovf_pos || w_ovf_neg) begin
                    r_sat <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    // Job start clears the result; overrides the accumulate above.
                    if (start) begin
                        r_acc       <= '0;
                        r_sat       <= 1'b0;
                        r_remaining <= w_len_clamped;
                        r_state     <= (w_len_clamped == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_fire) begin
                        r_remaining <= r_remaining - 1'b1;
                        if (r_remaining == LEN_WIDTH'(1)) begin
                            r_state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pe_mac_controller.sv
// Directed bench for pe_mac_controller: a 24-bit and a 16-bit accumulator instance,
// each paired with a behavioural registered-multiplier PE.
module tb_pe_mac_controller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              start_a, start_b;
    logic [8:0]        len;
    logic              in_valid;
    logic [7:0]        in_ifm, in_wgt;
    logic              out_ready;

    logic              busy_a, in_ready_a, out_valid_a, out_sat_a;
    logic [7:0]        pe_ifm_a, pe_wgt_a;
    logic [15:0]       pe_prod_a;
    logic [23:0]       out_acc_a;

    logic              busy_b, in_ready_b, out_valid_b, out_sat_b;
    logic [7:0]        pe_ifm_b, pe_wgt_b;
    logic [15:0]       pe_prod_b;
    logic [15:0]       out_acc_b;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] vi [0:7];
    logic [7:0] vw [0:7];
    bit         sel_b = 1'b0;

    pe_mac_controller u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .len(len), .busy(busy_a),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_ifm(in_ifm), .in_wgt(in_wgt),
        .pe_ifm(pe_ifm_a), .pe_wgt(pe_wgt_a), .pe_product(pe_prod_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_acc(out_acc_a), .out_sat(out_sat_a)
    );

    pe_mac_controller #(.ACC_WIDTH(16)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .len(len), .busy(busy_b),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_ifm(in_ifm), .in_wgt(in_wgt),
        .pe_ifm(pe_ifm_b), .pe_wgt(pe_wgt_b), .pe_product(pe_prod_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_acc(out_acc_b), .out_sat(out_sat_b)
    );

    always @(posedge clk) begin
        pe_prod_a <= 16'($signed(pe_ifm_a) * $signed(pe_wgt_a));
        pe_prod_b <= 16'($signed(pe_ifm_b) * $signed(pe_wgt_b));
    end

    logic sel_valid, sel_ready;
    assign sel_valid = sel_b ? out_valid_b : out_valid_a;
    assign sel_ready = sel_b ? in_ready_b  : in_ready_a;

    // Runs one job on the selected instance; returns at the first out_valid cycle.
    task automatic do_job(input bit b, input int n, input bit toggle,
                          output int vcyc, output logic signed [23:0] acc,
                          output logic sat, output bit rdy_ok);
        int idx;
        sel_b = b;
        @(negedge clk);
        len = n[8:0];
        if (b) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        idx = 0;
        vcyc = -1;
        rdy_ok = 1'b1;
        for (int c = 1; c < 60; c++) begin
            if (sel_valid) begin
                vcyc = c;
                break;
            end
            if (idx < n && !sel_ready) rdy_ok = 1'b0;
            in_valid = (idx < n) && (!toggle || (c % 2 == 0));
            if (in_valid) begin
                in_ifm = vi[idx];
                in_wgt = vw[idx];
            end else begin
                in_ifm = 8'h5A;
                in_wgt = 8'hA5;
            end
            if (in_valid && sel_ready) idx++;
            @(negedge clk);
        end
        in_valid = 1'b0;
        acc = b ? 24'($signed(out_acc_b)) : $signed(out_acc_a);
        sat = b ? out_sat_b : out_sat_a;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy_a, in_ready_a, out_valid_a, out_sat_a} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctl: busy/in_ready/out_valid/out_sat=%b required 0000",
                     {busy_a, in_ready_a, out_valid_a, out_sat_a});
        end
        n_vec++;
        if (out_acc_a !== 24'd0 || pe_ifm_a !== 8'd0 || pe_wgt_a !== 8'd0) begin
            n_err++;
            $display("FAIL reset_data: acc=%0d pe_ifm=%0d pe_wgt=%0d required 0 0 0",
                     out_acc_a, pe_ifm_a, pe_wgt_a);
        end
        rst = 1'b0;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        int vcyc; logic signed [23:0] acc; logic sat; bit ok;
        for (int k = 0; k < 4; k++) begin vi[k] = 8'(k + 1); vw[k] = 8'(k + 1); end
        out_ready = 1'b1;
        do_job(1'b0, 4, 1'b0, vcyc, acc, sat, ok);
        n_vec++;
        if (vcyc !== 6) begin n_err++; $display("FAIL basic_latency: out_valid at cycle %0d required 6", vcyc); end
        n_vec++;
        if (acc !== 24'sd30 || sat !== 1'b0) begin
            n_err++; $display("FAIL basic_acc: acc=%0d sat=%b required 30 0", acc, sat);
        end
        @(negedge clk);
        n_vec++;
        if (busy_a !== 1'b0) begin n_err++; $display("FAIL basic_busy_drop: busy=%b required 0", busy_a); end
        $display("test_basic: acc=%0d valid_cycle=%0d", acc, vcyc);
    endtask

    task automatic test_bubbles();
        int vcyc; logic signed [23:0] acc; logic sat; bit ok;
        out_ready = 1'b1;
        do_job(1'b0, 4, 1'b1, vcyc, acc, sat, ok);
        n_vec++;
        if (vcyc !== 10) begin n_err++; $display("FAIL bubble_latency: out_valid at cycle %0d required 10", vcyc); end
        n_vec++;
        if (acc !== 24'sd30) begin n_err++; $display("FAIL bubble_acc: acc=%0d required 30", acc); end
        n_vec++;
        if (ok !== 1'b1) begin n_err++; $display("FAIL bubble_in_ready: in_ready dropped during RUN (ok=%b) required 1", ok); end
        @(negedge clk);
        $display("test_bubbles: acc=%0d valid_cycle=%0d", acc, vcyc);
    endtask

    task automatic test_signed();
        int vcyc; logic signed [23:0] acc; logic sat; bit ok;
        vi[0] = 8'h80; vw[0] = 8'h80;
        vi[1] = 8'h7F; vw[1] = 8'h80;
        vi[2] = 8'hFF; vw[2] = 8'h01;
        out_ready = 1'b1;
        do_job(1'b0, 3, 1'b0, vcyc, acc, sat, ok);
        n_vec++;
        if (acc !== 24'sd127 || sat !== 1'b0) begin
            n_err++; $display("FAIL signed_acc: acc=%0d sat=%b required 127 0", acc, sat);
        end
        @(negedge clk);
        $display("test_signed: acc=%0d sat=%b", acc, sat);
    endtask

    task automatic test_saturation();
        int vcyc; logic signed [23:0] acc; logic sat; bit ok;
        for (int k = 0; k < 3; k++) begin vi[k] = 8'h80; vw[k] = 8'h80; end
        out_ready = 1'b1;
        do_job(1'b1, 3, 1'b0, vcyc, acc, sat, ok);
        n_vec++;
        if (acc !== 24'sd32767 || sat !== 1'b1) begin
            n_err++; $display("FAIL sat_clamp: acc=%0d sat=%b required 32767 1", acc, sat);
        end
        @(negedge clk);
        vi[0] = 8'd2; vw[0] = 8'd3;
        do_job(1'b1, 1, 1'b0, vcyc, acc, sat, ok);
        n_vec++;
        if (acc !== 24'sd6 || sat !== 1'b0) begin
            n_err++; $display("FAIL sat_clear_next_job: acc=%0d sat=%b required 6 0", acc, sat);
        end
        @(negedge clk);
        sel_b = 1'b0;
        $display("test_saturation: second job acc=%0d sat=%b", acc, sat);
    endtask

    task automatic test_zero_len_hold();
        int vcyc; logic signed [23:0] acc; logic sat; bit ok; bit stable;
        out_ready = 1'b0;
        do_job(1'b0, 0, 1'b0, vcyc, acc, sat, ok);
        n_vec++;
        if (vcyc !== 1) begin n_err++; $display("FAIL zero_len_latency: out_valid at cycle %0d required 1", vcyc); end
        n_vec++;
        if (acc !== 24'sd0) begin n_err++; $display("FAIL zero_len_acc: acc=%0d required 0", acc); end
        stable = 1'b1;
        for (int k = 0; k < 5; k++) begin
            start_a = ~start_a;
            len = 9'd3;
            @(negedge clk);
            if (out_valid_a !== 1'b1 || out_acc_a !== 24'd0 || out_sat_a !== 1'b0 || busy_a !== 1'b1)
                stable = 1'b0;
        end
        start_a = 1'b0;
        n_vec++;
        if (stable !== 1'b1) begin n_err++; $display("FAIL hold_stable: stable=%b required 1", stable); end
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (busy_a !== 1'b0 || out_valid_a !== 1'b0) begin
            n_err++; $display("FAIL hold_release: busy=%b out_valid=%b required 0 0", busy_a, out_valid_a);
        end
        $display("test_zero_len_hold: stable=%b", stable);
    endtask

    task automatic test_reset_mid_job();
        int vcyc; logic signed [23:0] acc; logic sat; bit ok;
        out_ready = 1'b1;
        len = 9'd5;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        in_valid = 1'b1; in_ifm = 8'd7; in_wgt = 8'd9;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if ({busy_a, in_ready_a, out_valid_a} !== 3'b000) begin
            n_err++; $display("FAIL midrst_ctl: busy/in_ready/out_valid=%b required 000",
                              {busy_a, in_ready_a, out_valid_a});
        end
        n_vec++;
        if (pe_ifm_a !== 8'd0 || pe_wgt_a !== 8'd0) begin
            n_err++; $display("FAIL midrst_pe: pe_ifm=%0d pe_wgt=%0d required 0 0", pe_ifm_a, pe_wgt_a);
        end
        in_valid = 1'b0;
        vi[0] = 8'd5; vw[0] = 8'hFD;
        do_job(1'b0, 1, 1'b0, vcyc, acc, sat, ok);
        n_vec++;
        if (acc !== -24'sd15) begin n_err++; $display("FAIL midrst_new_job: acc=%0d required -15", acc); end
        @(negedge clk);
        $display("test_reset_mid_job: new job acc=%0d", acc);
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; len = '0;
        in_valid = 1'b0; in_ifm = '0; in_wgt = '0; out_ready = 1'b1;
        test_reset();
        test_basic();
        test_bubbles();
        test_signed();
        test_saturation();
        test_zero_len_hold();
        test_reset_mid_job();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
